// File: rtl/axi_mem_if_pkg.sv
// rtl/axi_mem_if_pkg.sv - shared constants and response tag for the multi-port memory arbiter
// Response latency depends on optional macro AXI_MEM_IF_MP_RDATA_REG_EN.
package axi_mem_if_pkg;

`ifdef AXI_MEM_IF_MP_RDATA_REG_EN
    localparam int RESP_LAT = 2;
`else
    localparam int RESP_LAT = 1;
`endif

    localparam int PORT_IDX_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [PORT_IDX_W-1:0] port;
        logic                  is_write;
    } resp_tag_t;

endpackage

// File: rtl/axi_mem_if_mp_mem_arb_if.sv
// rtl/axi_mem_if_mp_mem_arb_if.sv - requester and memory-side signal bundle of the arbiter
interface axi_mem_if_mp_mem_arb_if #(
    parameter int NB_PORTS       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 13
);
    logic [NB_PORTS-1:0]                req_i;
    logic [NB_PORTS-1:0]                we_i;
    logic [NB_PORTS*MEM_ADDR_WIDTH-1:0] addr_i;
    logic [NB_PORTS*DATA_WIDTH-1:0]     wdata_i;
    logic [NB_PORTS*BE_WIDTH-1:0]       be_i;
    logic [NB_PORTS-1:0]                gnt_o;
    logic [NB_PORTS-1:0]                rvalid_o;
    logic [DATA_WIDTH-1:0]              rdata_o;
    logic                               CEN_o;
    logic                               WEN_o;
    logic [MEM_ADDR_WIDTH-1:0]          A_o;
    logic [DATA_WIDTH-1:0]              D_o;
    logic [BE_WIDTH-1:0]                BE_o;
    logic [DATA_WIDTH-1:0]              Q_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, Q_i,
        output gnt_o, rvalid_o, rdata_o, CEN_o, WEN_o, A_o, D_o, BE_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, Q_i,
        input  gnt_o, rvalid_o, rdata_o, CEN_o, WEN_o, A_o, D_o, BE_o
    );
endinterface

// File: rtl/axi_mem_if_rr_arb.sv
// rtl/axi_mem_if_rr_arb.sv - combinational round-robin pick from a priority pointer
module axi_mem_if_rr_arb #(
    parameter int NB_PORTS = 4,
    parameter int PTR_W    = $clog2(NB_PORTS)
) (
    input  logic [NB_PORTS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [NB_PORTS-1:0] gnt,
    output logic [PTR_W-1:0]    gnt_idx,
    output logic                gnt_any,
    output logic [PTR_W-1:0]    ptr_nxt
);
    int idx;

    // Scan ports starting at ptr; the first requester wins and ptr moves past it.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        ptr_nxt = ptr;
        idx     = 0;
        for (int i = 0; i < NB_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NB_PORTS) begin
                idx = idx - NB_PORTS;
            end
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                ptr_nxt  = (idx == NB_PORTS - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end
endmodule

// File: rtl/axi_mem_if_mp_mem_arb.sv
// rtl/axi_mem_if_mp_mem_arb.sv - round-robin N-port arbiter onto one single-port memory
// Optional macro AXI_MEM_IF_MP_RDATA_REG_EN adds a read-data register stage.
module axi_mem_if_mp_mem_arb
    import axi_mem_if_pkg::*;
#(
    parameter int NB_PORTS       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 13
) (
    input logic                      clk,
    input logic                      rst,
    axi_mem_if_mp_mem_arb_if.slave   bus
);
    localparam int PTR_W = $clog2(NB_PORTS);

    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [PTR_W-1:0]    gnt_idx;
    logic [NB_PORTS-1:0] arb_gnt;
    logic                gnt_any;
    logic                grant_ok;
    resp_tag_t           tag_new;
    resp_tag_t           tag1_q;
    resp_tag_t           tag_out;
    logic [DATA_WIDTH-1:0] rdata_src;
    logic                unused_tag_bits;

    axi_mem_if_rr_arb #(
        .NB_PORTS (NB_PORTS),
        .PTR_W    (PTR_W)
    ) u_rr_arb (
        .req     (bus.req_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any),
        .ptr_nxt (ptr_nxt)
    );

    assign grant_ok = gnt_any & ~rst;

    always_comb begin
        bus.gnt_o = grant_ok ? arb_gnt : '0;
        bus.CEN_o = 1'b1;
        bus.WEN_o = 1'b1;
        bus.A_o   = '0;
        bus.D_o   = '0;
        bus.BE_o  = '0;
        if (grant_ok) begin
            bus.CEN_o = 1'b0;
            bus.WEN_o = ~bus.we_i[gnt_idx];
            bus.A_o   = bus.addr_i[int'(gnt_idx)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            bus.D_o   = bus.wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            bus.BE_o  = bus.be_i[int'(gnt_idx)*BE_WIDTH +: BE_WIDTH];
        end
    end

    always_comb begin
        tag_new          = '0;
        tag_new.valid    = grant_ok;
        tag_new.port     = PORT_IDX_W'(gnt_idx);
        tag_new.is_write = bus.we_i[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            tag1_q <= '0;
        end else begin
            if (grant_ok) begin
                ptr_q <= ptr_nxt;
            end
            tag1_q <= tag_new;
        end
    end

`ifdef AXI_MEM_IF_MP_RDATA_REG_EN
    resp_tag_t             tag2_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag2_q <= '0;
        end else begin
            tag2_q <= tag1_q;
        end
    end

    // Data register is not reset: it is only looked at alongside a valid tag.
    always_ff @(posedge clk) begin
        rdata_q <= bus.Q_i;
    end

    assign tag_out   = tag2_q;
    assign rdata_src = rdata_q;
`else
    assign tag_out   = tag1_q;
    assign rdata_src = bus.Q_i;
`endif

    // rvalid is also masked combinationally so a reset cycle never shows a response.
    always_comb begin
        bus.rvalid_o = '0;
        if (!rst && tag_out.valid) begin
            bus.rvalid_o[tag_out.port[PTR_W-1:0]] = 1'b1;
        end
    end

    assign bus.rdata_o     = rdata_src;
    assign unused_tag_bits = ^{tag_out.port, tag_out.is_write};
endmodule
